// File: rtl/branch_resolve_stage.sv
// rtl/branch_resolve_stage.sv - EX-stage branch resolution, redirect/flush FSM and bimodal BHT (optional BRANCH_PERF_CNT_EN perf counters)
module branch_resolve_stage #(
   parameter int XLEN         = 32,
   parameter int BHT_ENTRIES  = 64,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic            ex_is_jump,
   input  logic            ex_token,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   input  logic            stall,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush
`ifdef BRANCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] perf_branches,
   output logic [XLEN-1:0] perf_mispredicts
`endif
);

   localparam int IDXW     = $clog2(BHT_ENTRIES);
   localparam int CNTW     = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
   localparam int LOAD_INT = (FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0;
   localparam logic [CNTW-1:0] FLUSH_LOAD = LOAD_INT[CNTW-1:0];

   typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

   state_t          state;
   logic [CNTW-1:0] flush_cnt;
   logic [1:0]      bht [BHT_ENTRIES];

   logic            accept;
   logic            actual_taken;
   logic [XLEN-1:0] actual_next;
   logic            mispredict;
   logic [IDXW-1:0] upd_idx;
   logic [IDXW-1:0] rd_idx;
   logic            unused_if_pc;

   // Wrong-path instructions (anything seen outside IDLE) never reach resolution.
   assign accept       = ex_valid & ~stall & (state == IDLE) & (ex_is_branch | ex_is_jump);
   assign actual_taken = ex_is_jump | (ex_is_branch & ex_token);
   assign actual_next  = actual_taken ? ex_target : ex_pc + XLEN'(4);
   assign mispredict   = (actual_taken != ex_pred_taken) |
                         (actual_taken & (ex_pred_target != ex_target));

   assign upd_idx       = ex_pc[IDXW+1:2];
   assign rd_idx        = if_pc[IDXW+1:2];
   assign if_pred_taken = bht[rd_idx][1];
   assign unused_if_pc  = ^{if_pc[XLEN-1:IDXW+2], if_pc[1:0]};

   // Redirect/flush sequencer: one REDIRECT cycle followed by the remaining flush cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         flush_cnt      <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && mispredict) begin
                  state          <= REDIRECT;
                  redirect_pc    <= actual_next;
                  redirect_valid <= 1'b1;
                  flush          <= 1'b1;
               end
            end
            REDIRECT: begin
               redirect_valid <= 1'b0;
               if (FLUSH_CYCLES == 1) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else begin
                  state     <= FLUSH;
                  flush_cnt <= FLUSH_LOAD;
                  flush     <= 1'b1;
               end
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= IDLE;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: begin
               state          <= IDLE;
               redirect_valid <= 1'b0;
               flush          <= 1'b0;
            end
         endcase
      end
   end

   // Bimodal training: only accepted conditional branches move their 2-bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (accept && ex_is_branch && !ex_is_jump) begin
         if (ex_token) begin
            if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
         end else begin
            if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
         end
      end
   end

`ifdef BRANCH_PERF_CNT_EN
   // Resolved-branch and mispredict event counters, free-running with wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else if (accept) begin
         perf_branches <= perf_branches + 1'b1;
         if (mispredict) perf_mispredicts <= perf_mispredicts + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// tb/tb_branch_resolve_stage.sv - directed scoreboard bench for branch_resolve_stage
module tb_branch_resolve_stage;
   localparam int XLEN = 32;
   localparam int ENT  = 64;
   localparam int FC   = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ex_valid, ex_is_branch, ex_is_jump, ex_token, ex_pred_taken, stall;
   logic [XLEN-1:0] ex_pc, ex_target, ex_pred_target, if_pc;
   logic            if_pred_taken, redirect_valid, flush;
   logic [XLEN-1:0] redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
   logic [XLEN-1:0] perf_branches, perf_mispredicts;
   logic [XLEN-1:0] pb_m, pm_m;
`endif

   logic [1:0]      bht_m [ENT];
   int              busy;
   logic [XLEN-1:0] exp_q [$];
   int              checks;
   int              errors;

   always #5 clk = ~clk;

   branch_resolve_stage #(.XLEN(XLEN), .BHT_ENTRIES(ENT), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
      .ex_token(ex_token), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .stall(stall), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
`ifdef BRANCH_PERF_CNT_EN
      , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
   );

   function automatic int idx(input logic [XLEN-1:0] pc);
      return int'(pc[7:2]);
   endfunction

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset;
      busy = 0;
      foreach (bht_m[i]) bht_m[i] = 2'b01;
      exp_q.delete();
`ifdef BRANCH_PERF_CNT_EN
      pb_m = '0;
      pm_m = '0;
`endif
   endtask

   task automatic drv(input logic v, input logic br, input logic jmp, input logic tok,
                      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                      input logic pt, input logic [XLEN-1:0] ptgt);
      ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_token = tok;
      ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   // One clock: predict the edge from the driven inputs, then check at the falling edge.
   task automatic tick;
      logic acc, taken, mis, fired;
      logic [XLEN-1:0] nxt;
      int k;
      acc   = ex_valid && !stall && (busy == 0) && (ex_is_branch || ex_is_jump);
      taken = ex_is_jump || (ex_is_branch && ex_token);
      nxt   = taken ? ex_target : ex_pc + 32'd4;
      mis   = (taken != ex_pred_taken) || (taken && (ex_pred_target != ex_target));
      k     = idx(ex_pc);
      @(posedge clk);
      fired = 1'b0;
      if (busy > 0) busy--;
      if (acc && mis) begin
         busy = FC;
         exp_q.push_back(nxt);
         fired = 1'b1;
      end
      if (acc && ex_is_branch && !ex_is_jump) begin
         if (ex_token && bht_m[k] != 2'b11) bht_m[k] = bht_m[k] + 2'b01;
         else if (!ex_token && bht_m[k] != 2'b00) bht_m[k] = bht_m[k] - 2'b01;
      end
`ifdef BRANCH_PERF_CNT_EN
      if (acc) pb_m = pb_m + 1;
      if (acc && mis) pm_m = pm_m + 1;
`endif
      @(negedge clk);
      chk("flush", {31'b0, flush}, {31'b0, busy > 0});
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, fired});
      if (redirect_valid) begin
         chk("redirect_expected", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) chk("redirect_pc", redirect_pc, exp_q.pop_front());
      end
      chk("if_pred_taken", {31'b0, if_pred_taken}, {31'b0, bht_m[idx(if_pc)][1]});
`ifdef BRANCH_PERF_CNT_EN
      chk("perf_branches", perf_branches, pb_m);
      chk("perf_mispredicts", perf_mispredicts, pm_m);
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      stall  = 1'b0;
      if_pc  = 32'h100;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_pred_0x100", {31'b0, if_pred_taken}, 32'd0);
      rst_n = 1'b1;

      // Taken branch predicted not-taken: redirect to target, counter 01->10.
      drv(1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h0);
      tick();
      chk("redirect_0x80", redirect_pc, 32'h80);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("pred_0x100_trained", {31'b0, if_pred_taken}, 32'd1);

      // Not-taken mispredict at top of address space: fall-through wraps to 0.
      if_pc = 32'hFFFF_FFFC;
      drv(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10);
      tick();
      chk("redirect_wrap", redirect_pc, 32'h0);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      drv(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 0, 32'h10);
      repeat (3) tick();
      drv(1, 1, 0, 1, 32'hFFFF_FFFC, 32'h10, 1, 32'h10);
      tick();
      chk("bht_saturate_low", {31'b0, if_pred_taken}, 32'd0);

      // Jump with wrong predicted target; jumps do not train.
      if_pc = 32'h200;
      drv(1, 0, 1, 0, 32'h200, 32'h304, 1, 32'h300);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("redirect_hold_0x304", redirect_pc, 32'h304);

      // Correct prediction, then a stalled mispredict that resolves once stall drops.
      if_pc = 32'h40;
      drv(1, 1, 0, 1, 32'h40, 32'h500, 1, 32'h500);
      tick();
      if_pc = 32'h44;
      drv(1, 1, 0, 1, 32'h44, 32'h600, 0, 32'h0);
      stall = 1'b1;
      repeat (3) tick();
      stall = 1'b0;
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Branch presented during REDIRECT is wrong-path and ignored.
      if_pc = 32'h64;
      drv(1, 1, 0, 1, 32'h60, 32'h700, 0, 32'h0);
      tick();
      drv(1, 1, 0, 1, 32'h64, 32'h800, 0, 32'h0);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("redirect_pc_not_0x800", redirect_pc, 32'h700);

      // Same-cycle lookup of an entry being updated sees the old counter.
      if_pc = 32'h40;
      drv(1, 1, 0, 0, 32'h40, 32'h500, 0, 32'h500);
      #1;
      chk("read_before_write", {31'b0, if_pred_taken}, 32'd1);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset in the middle of a flush aborts it and restores the table.
      if_pc = 32'h100;
      drv(1, 1, 0, 1, 32'h80, 32'h900, 0, 32'h0);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midflush_rst_flush", {31'b0, flush}, 32'd0);
      chk("midflush_rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
      chk("midflush_rst_redirect_pc", redirect_pc, 32'd0);
      chk("midflush_rst_bht", {31'b0, if_pred_taken}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_resolve_stage.md
Name: branch_resolve_stage

Overview:
Sits directly downstream of the EX-stage branch comparator and consumes its taken/not-taken token. Compares the resolved outcome against the fetch-time prediction and, on mismatch, issues a registered PC redirect plus a multi-cycle pipeline flush. It also trains a bimodal table of 2-bit saturating counters and serves the table's prediction to fetch.

Parameters:
XLEN, 32, address/data width
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >= 2
FLUSH_CYCLES, 2, total cycles flush is held per mispredict; >= 1

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX slot holds a valid instruction
ex_is_branch  in  1  conditional branch (BEQ..BGEU)
ex_is_jump  in  1  unconditional jump (JAL/JALR), always taken
ex_token  in  1  branch comparator result, 1 = condition true
ex_pc  in  XLEN  PC of EX instruction
ex_target  in  XLEN  computed taken target
ex_pred_taken  in  1  prediction carried from fetch
ex_pred_target  in  XLEN  predicted target carried from fetch
stall  in  1  EX held by downstream; instruction not accepted
if_pc  in  XLEN  fetch PC for prediction lookup
if_pred_taken  out  1  prediction for if_pc (combinational)
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  XLEN  corrected next PC
flush  out  1  squash younger instructions in IF/ID/EX

Behaviour:
- Reset (async, rst_n low): state IDLE, redirect_valid=0, redirect_pc=0, flush=0, every BHT entry = 2'b01 (weakly not-taken). Reset asserted mid-flush aborts the flush immediately.
- Accept = ex_valid & ~stall & (state==IDLE) & (ex_is_branch | ex_is_jump). In REDIRECT/FLUSH the EX instruction is wrong-path: ignored, no BHT update.
- actual_taken = ex_is_jump | (ex_is_branch & ex_token). Both is_branch and is_jump set: treated as a jump.
- actual_next = actual_taken ? ex_target : ex_pc + 4 (mod 2^XLEN, wrap-around allowed).
- mispredict = (actual_taken != ex_pred_taken) | (actual_taken & ex_pred_target != ex_target).
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE: Accept & mispredict -> REDIRECT, with redirect_pc <= actual_next registered on that edge.
  - REDIRECT: exactly 1 cycle. redirect_valid=1, flush=1. If FLUSH_CYCLES==1 -> IDLE, else -> FLUSH with counter loaded to FLUSH_CYCLES-2.
  - FLUSH: flush=1, redirect_valid=0. Counter==0 -> IDLE, else decrement.
- Latency: redirect_valid rises on the cycle after the accepting edge. flush is high for exactly FLUSH_CYCLES consecutive cycles starting there.
- stall does not pause the REDIRECT/FLUSH sequence; flush overrides stall.
- redirect_pc holds its value after the pulse until the next mispredict.
- BHT index = pc[log2(BHT_ENTRIES)+1:2].
  - Update on Accept with conditional branch only (jumps do not train): taken -> saturating increment (max 2'b11), not-taken -> saturating decrement (min 2'b00). Update is independent of mispredict.
  - if_pred_taken = bht[idx(if_pc)][1].
  - Read-before-write: a lookup in the same cycle as an update to the same entry returns the old value.

Optional Feature:
BRANCH_PERF_CNT_EN: adds outputs perf_branches and perf_mispredicts (XLEN each).
- Reset to 0. perf_branches increments on every Accept; perf_mispredicts increments on Accept & mispredict. Both wrap at 2^XLEN.
Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read if_pc=0x100 -> if_pred_taken=0. Drive rst_n low mid-FLUSH -> flush=0 and redirect_valid=0 immediately, BHT back to 01.
- Branch at pc=0x100, token=1, pred_taken=0, target=0x80 -> next cycle redirect_valid=1, redirect_pc=0x80. flush high 2 cycles (FLUSH_CYCLES=2). bht[0x100] goes 01->10, so if_pred_taken=1.
- Branch token=0, pred_taken=1, pc=0xFFFFFFFC -> redirect_pc=0x00000000 (wrap). Counter saturates at 00 after repeated not-taken.
- JAL pc=0x200, pred_taken=1, pred_target=0x300, target=0x304 -> target mismatch, redirect_pc=0x304. BHT entry for 0x200 unchanged.
- Correct prediction (token=1, pred_taken=1, targets equal) -> no redirect, no flush. With stall=1 held 3 cycles -> no accept and no BHT update until stall drops.
- Mispredict followed by a valid branch in the REDIRECT cycle -> second branch ignored. With BRANCH_PERF_CNT_EN, perf_branches=1 and perf_mispredicts=1.
